// File: rtl/jpeg_sof_parser.sv
// Byte-serial JPEG SOF0/SOF1 frame header parser. Stores per-component sampling and
// quantiser selection, validates the header and derives the MCU grid.
module jpeg_sof_parser #(
  parameter int unsigned MAX_COMP = 4,
  parameter int unsigned MCU_BITS = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sof_start,
  input  logic                  frm_clr,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  co_en,
  output logic                  co_err,
  output logic [2:0]            co_err_code,
  output logic [15:0]           co_width,
  output logic [15:0]           co_height,
  output logic [2:0]            co_ncomp,
  output logic [3*MAX_COMP-1:0] co_hfac,
  output logic [3*MAX_COMP-1:0] co_vfac,
  output logic [2*MAX_COMP-1:0] co_qt,
  output logic [2:0]            co_hmax,
  output logic [2:0]            co_vmax,
  output logic [3:0]            co_blk_per_mcu,
  output logic [MCU_BITS-1:0]   co_mcu_w,
  output logic [MCU_BITS-1:0]   co_mcu_h
);

  localparam logic [3:0] StIdle  = 4'd0,  StLenHi = 4'd1,  StLenLo = 4'd2,  StPrec = 4'd3;
  localparam logic [3:0] StYHi   = 4'd4,  StYLo   = 4'd5,  StXHi   = 4'd6,  StXLo  = 4'd7;
  localparam logic [3:0] StNf    = 4'd8,  StCId   = 4'd9,  StCHv   = 4'd10, StCTq  = 4'd11;
  localparam logic [3:0] StCalc  = 4'd12, StDone  = 4'd13, StErr   = 4'd14;

  logic [3:0]            st_q, st_d;
  logic [2:0]            comp_q, comp_d;
  logic [15:0]           lf_q, lf_d;
  logic                  en_q, en_d, err_q, err_d;
  logic [2:0]            code_q, code_d;
  logic [15:0]           width_q, width_d, height_q, height_d;
  logic [2:0]            ncomp_q, ncomp_d;
  logic [3*MAX_COMP-1:0] hfac_q, hfac_d, vfac_q, vfac_d;
  logic [2*MAX_COMP-1:0] qt_q, qt_d;
  logic [2:0]            hmax_q, hmax_d, vmax_q, vmax_d;
  logic [3:0]            blk_q, blk_d;
  logic [MCU_BITS-1:0]   mcu_w_q, mcu_w_d, mcu_h_q, mcu_h_d;

  logic                  fail;
  logic [2:0]            fail_code;
  logic [3:0]            h_fac, v_fac;
  logic [4:0]            blk_sum;

  function automatic logic fac_ok(input logic [3:0] f);
    return (f == 4'd1) || (f == 4'd2) || (f == 4'd4);
  endfunction

  // ceil(val / (8*fac)); fac is one of 1/2/4, so log2 is just its upper two bits.
  function automatic logic [15:0] ceil_div(input logic [15:0] val, input logic [2:0] fac);
    logic [2:0]  sh;
    logic [15:0] mask;
    sh   = 3'd3 + {1'b0, fac[2], fac[1]};
    mask = (16'd1 << sh) - 16'd1;
    return (val >> sh) + {15'd0, |(val & mask)};
  endfunction

  assign h_fac    = in_data[7:4];
  assign v_fac    = in_data[3:0];
  assign blk_sum  = {1'b0, blk_q} + ({2'b00, h_fac[2:0]} * {2'b00, v_fac[2:0]});
  assign in_ready = (st_q >= StLenHi) && (st_q <= StCTq);

  always_comb begin
    st_d = st_q;  comp_d = comp_q;  lf_d = lf_q;
    en_d = en_q;  err_d = err_q;  code_d = code_q;
    width_d = width_q;  height_d = height_q;  ncomp_d = ncomp_q;
    hfac_d = hfac_q;  vfac_d = vfac_q;  qt_d = qt_q;
    hmax_d = hmax_q;  vmax_d = vmax_q;  blk_d = blk_q;
    mcu_w_d = mcu_w_q;  mcu_h_d = mcu_h_q;
    fail = 1'b0;
    fail_code = 3'd0;

    if (in_valid && in_ready) begin
      case (st_q)
        StLenHi: begin lf_d[15:8] = in_data;  st_d = StLenLo; end
        StLenLo: begin lf_d[7:0] = in_data;  st_d = StPrec; end
        StPrec: begin
          if (in_data != 8'd8) begin fail = 1'b1;  fail_code = 3'd1; end
          else st_d = StYHi;
        end
        StYHi: begin height_d[15:8] = in_data;  st_d = StYLo; end
        StYLo: begin height_d[7:0] = in_data;  st_d = StXHi; end
        StXHi: begin width_d[15:8] = in_data;  st_d = StXLo; end
        StXLo: begin width_d[7:0] = in_data;  st_d = StNf; end
        StNf: begin
          ncomp_d = in_data[2:0];
          if (in_data == 8'd0 || in_data == 8'd2 || in_data > 8'(MAX_COMP)) begin
            fail = 1'b1;  fail_code = 3'd2;
          end else if (lf_q != 16'd8 + 16'd3 * {8'd0, in_data}) begin
            fail = 1'b1;  fail_code = 3'd5;
          end else if (width_q == 16'd0 || height_q == 16'd0) begin
            fail = 1'b1;  fail_code = 3'd6;
          end else begin
            comp_d = 3'd0;
            st_d   = StCId;
          end
        end
        StCId: st_d = StCHv;
        StCHv: begin
          if (!fac_ok(h_fac) || !fac_ok(v_fac)) begin
            fail = 1'b1;  fail_code = 3'd3;
          end else begin
            for (int unsigned i = 0; i < MAX_COMP; i++) begin
              if (comp_q == 3'(i)) begin
                hfac_d[3*i +: 3] = h_fac[2:0];
                vfac_d[3*i +: 3] = v_fac[2:0];
              end
            end
            if (h_fac[2:0] > hmax_q) hmax_d = h_fac[2:0];
            if (v_fac[2:0] > vmax_q) vmax_d = v_fac[2:0];
            blk_d = (blk_sum > 5'd15) ? 4'd15 : blk_sum[3:0];
            st_d  = StCTq;
          end
        end
        StCTq: begin
          if (in_data > 8'd3) begin
            fail = 1'b1;  fail_code = 3'd4;
          end else begin
            for (int unsigned i = 0; i < MAX_COMP; i++) begin
              if (comp_q == 3'(i)) qt_d[2*i +: 2] = in_data[1:0];
            end
            if (comp_q == ncomp_q - 3'd1) st_d = StCalc;
            else begin
              comp_d = comp_q + 3'd1;
              st_d   = StCId;
            end
          end
        end
        default: ;
      endcase
    end

    if (st_q == StCalc) begin
      mcu_w_d = MCU_BITS'(ceil_div(width_q, hmax_q));
      mcu_h_d = MCU_BITS'(ceil_div(height_q, vmax_q));
      if (blk_q > 4'd10) begin
        fail = 1'b1;  fail_code = 3'd7;
      end else begin
        en_d = 1'b1;
        st_d = StDone;
      end
    end

    if (fail) begin
      st_d = StErr;  err_d = 1'b1;  code_d = fail_code;
    end

    // A new SOF always restarts from a clean slate, including the running maxima/sums.
    if (sof_start) begin
      st_d = StLenHi;  comp_d = '0;  lf_d = '0;
      en_d = 1'b0;  err_d = 1'b0;  code_d = '0;
      width_d = '0;  height_d = '0;  ncomp_d = '0;
      hfac_d = '0;  vfac_d = '0;  qt_d = '0;
      hmax_d = '0;  vmax_d = '0;  blk_d = '0;
      mcu_w_d = '0;  mcu_h_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || frm_clr) begin
      st_q <= StIdle;  comp_q <= '0;  lf_q <= '0;
      en_q <= 1'b0;  err_q <= 1'b0;  code_q <= '0;
      width_q <= '0;  height_q <= '0;  ncomp_q <= '0;
      hfac_q <= '0;  vfac_q <= '0;  qt_q <= '0;
      hmax_q <= '0;  vmax_q <= '0;  blk_q <= '0;
      mcu_w_q <= '0;  mcu_h_q <= '0;
    end else begin
      st_q <= st_d;  comp_q <= comp_d;  lf_q <= lf_d;
      en_q <= en_d;  err_q <= err_d;  code_q <= code_d;
      width_q <= width_d;  height_q <= height_d;  ncomp_q <= ncomp_d;
      hfac_q <= hfac_d;  vfac_q <= vfac_d;  qt_q <= qt_d;
      hmax_q <= hmax_d;  vmax_q <= vmax_d;  blk_q <= blk_d;
      mcu_w_q <= mcu_w_d;  mcu_h_q <= mcu_h_d;
    end
  end

  assign co_en          = en_q;
  assign co_err         = err_q;
  assign co_err_code    = code_q;
  assign co_width       = width_q;
  assign co_height      = height_q;
  assign co_ncomp       = ncomp_q;
  assign co_hfac        = hfac_q;
  assign co_vfac        = vfac_q;
  assign co_qt          = qt_q;
  assign co_hmax        = hmax_q;
  assign co_vmax        = vmax_q;
  assign co_blk_per_mcu = blk_q;
  assign co_mcu_w       = mcu_w_q;
  assign co_mcu_h       = mcu_h_q;

endmodule

// File: tb/tb_jpeg_sof_parser.sv
// Bench for jpeg_sof_parser: directed and randomized SOF headers checked against a
// byte-list reference parser.
module tb_jpeg_sof_parser;
  localparam int MC = 4;
  localparam int MB = 13;

  typedef logic [7:0] bq_t [$];
  typedef struct packed {
    logic          en;
    logic          err;
    logic [2:0]    code;
    int            nbytes;
    logic [15:0]   width;
    logic [15:0]   height;
    logic [2:0]    ncomp;
    logic [3*MC-1:0] hfac;
    logic [3*MC-1:0] vfac;
    logic [2*MC-1:0] qt;
    logic [2:0]    hmax;
    logic [2:0]    vmax;
    logic [3:0]    blk;
    logic [MB-1:0] mcu_w;
    logic [MB-1:0] mcu_h;
  } exp_t;

  logic clk = 1'b0;
  logic rst, sof_start, frm_clr, in_valid, in_ready;
  logic [7:0] in_data;
  logic co_en, co_err;
  logic [2:0] co_err_code, co_ncomp, co_hmax, co_vmax;
  logic [15:0] co_width, co_height;
  logic [3*MC-1:0] co_hfac, co_vfac;
  logic [2*MC-1:0] co_qt;
  logic [3:0] co_blk_per_mcu;
  logic [MB-1:0] co_mcu_w, co_mcu_h;

  int tests = 0;
  int fails = 0;
  int gap_max = 0;

  jpeg_sof_parser #(.MAX_COMP(MC), .MCU_BITS(MB)) dut (
    .clk(clk), .rst(rst), .sof_start(sof_start), .frm_clr(frm_clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .co_en(co_en), .co_err(co_err), .co_err_code(co_err_code),
    .co_width(co_width), .co_height(co_height), .co_ncomp(co_ncomp),
    .co_hfac(co_hfac), .co_vfac(co_vfac), .co_qt(co_qt),
    .co_hmax(co_hmax), .co_vmax(co_vmax), .co_blk_per_mcu(co_blk_per_mcu),
    .co_mcu_w(co_mcu_w), .co_mcu_h(co_mcu_h)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, name, obs, exp);
    end
  endtask

  // Reference parser: walks the byte list in order, first failing rule wins.
  function automatic exp_t model(input bq_t q);
    exp_t e;
    int lf, nf, h, v, hmax, vmax, blk, cw, ch;
    e = '0;
    hmax = 0; vmax = 0; blk = 0;
    lf = int'({q[0], q[1]});
    e.nbytes = 3;
    if (q[2] != 8'd8) begin e.err = 1'b1; e.code = 3'd1; return e; end
    e.height = {q[3], q[4]};
    e.width  = {q[5], q[6]};
    nf = int'(q[7]);
    e.nbytes = 8;
    e.ncomp = 3'(nf);
    if (nf == 0 || nf == 2 || nf > MC) begin e.err = 1'b1; e.code = 3'd2; return e; end
    if (lf != 8 + 3 * nf) begin e.err = 1'b1; e.code = 3'd5; return e; end
    if (e.width == 16'd0 || e.height == 16'd0) begin e.err = 1'b1; e.code = 3'd6; return e; end
    for (int c = 0; c < nf; c++) begin
      h = int'(q[9 + 3*c][7:4]);
      v = int'(q[9 + 3*c][3:0]);
      e.nbytes = 10 + 3*c;
      if (!(h inside {1, 2, 4}) || !(v inside {1, 2, 4})) begin
        e.err = 1'b1; e.code = 3'd3; return e;
      end
      e.hfac[3*c +: 3] = 3'(h);
      e.vfac[3*c +: 3] = 3'(v);
      if (h > hmax) hmax = h;
      if (v > vmax) vmax = v;
      blk = (blk + h*v > 15) ? 15 : blk + h*v;
      e.nbytes = 11 + 3*c;
      if (q[10 + 3*c] > 8'd3) begin e.err = 1'b1; e.code = 3'd4; return e; end
      e.qt[2*c +: 2] = q[10 + 3*c][1:0];
    end
    e.hmax = 3'(hmax);
    e.vmax = 3'(vmax);
    e.blk  = 4'(blk);
    if (blk > 10) begin e.err = 1'b1; e.code = 3'd7; return e; end
    cw = (int'(e.width) + 8*hmax - 1) / (8*hmax);
    ch = (int'(e.height) + 8*vmax - 1) / (8*vmax);
    e.mcu_w = MB'(cw);
    e.mcu_h = MB'(ch);
    e.en = 1'b1;
    return e;
  endfunction

  function automatic bq_t mk_hdr(input int lf, input int p, input int y, input int x,
                                 input int nf, input logic [7:0] hv [4],
                                 input logic [7:0] tq [4]);
    bq_t q;
    q = {8'(lf >> 8), 8'(lf), 8'(p), 8'(y >> 8), 8'(y), 8'(x >> 8), 8'(x), 8'(nf)};
    for (int c = 0; c < ((nf > 4) ? 4 : nf); c++) begin
      q.push_back(8'(c + 1));
      q.push_back(hv[c]);
      q.push_back(tq[c]);
    end
    return q;
  endfunction

  function automatic logic [3:0] rand_fac();
    int s;
    s = int'($urandom_range(0, 12));
    if (s < 6) return 4'd1;
    if (s < 10) return 4'd2;
    if (s < 12) return 4'd4;
    return 4'd3;
  endfunction

  // Starts and ends 1ns after a rising edge; the byte is accepted at the last edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    int gap;
    n = 0;
    gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 8) begin @(posedge clk); #1; n++; end
    check("send", "in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check(tag, "en_err", {co_en, co_err}, 0);
    check(tag, "code", co_err_code, 0);
    check(tag, "geom", {co_width, co_height, co_ncomp}, 0);
    check(tag, "fac", {co_hfac, co_vfac, co_qt}, 0);
    check(tag, "max_blk", {co_hmax, co_vmax, co_blk_per_mcu}, 0);
    check(tag, "mcu", {co_mcu_w, co_mcu_h}, 0);
    check(tag, "in_ready", in_ready, 0);
  endtask

  task automatic run_header(input string tag, input bq_t q);
    exp_t e;
    e = model(q);
    sof_start = 1'b1;
    @(posedge clk); #1;
    sof_start = 1'b0;
    check(tag, "cleared", {co_en, co_err}, 0);
    for (int i = 0; i < e.nbytes; i++) send_byte(q[i]);
    if (e.err && e.code != 3'd7) begin
      check(tag, "err_immediate", co_err, 1);
    end else begin
      check(tag, "calc_cycle", {co_en, co_err}, 0);
      @(posedge clk); #1;
    end
    check(tag, "co_en", co_en, e.en);
    check(tag, "co_err", co_err, e.err);
    check(tag, "code", co_err_code, e.code);
    check(tag, "in_ready", in_ready, 0);
    if (e.en) begin
      check(tag, "width", co_width, e.width);
      check(tag, "height", co_height, e.height);
      check(tag, "ncomp", co_ncomp, e.ncomp);
      check(tag, "hfac", co_hfac, e.hfac);
      check(tag, "vfac", co_vfac, e.vfac);
      check(tag, "qt", co_qt, e.qt);
      check(tag, "hmax", co_hmax, e.hmax);
      check(tag, "vmax", co_vmax, e.vmax);
      check(tag, "blk", co_blk_per_mcu, e.blk);
      check(tag, "mcu_w", co_mcu_w, e.mcu_w);
      check(tag, "mcu_h", co_mcu_h, e.mcu_h);
    end
  endtask

  initial begin
    bq_t q;
    logic [7:0] hv [4];
    logic [7:0] tq [4];
    int nf, sel, lf, p, x, y;

    rst = 1'b0; sof_start = 1'b0; frm_clr = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // 4:2:0 VGA, back to back
    hv = '{8'h22, 8'h11, 8'h11, 8'h11};
    tq = '{8'd0, 8'd1, 8'd1, 8'd0};
    run_header("yuv420", mk_hdr(17, 8, 480, 640, 3, hv, tq));
    check("yuv420", "mcu_w_const", co_mcu_w, 40);
    check("yuv420", "mcu_h_const", co_mcu_h, 30);
    check("yuv420", "blk_const", co_blk_per_mcu, 6);
    check("yuv420", "qt_const", co_qt, 8'h14);
    repeat (3) @(posedge clk);
    #1;
    check("yuv420", "hold_en", co_en, 1);

    gap_max = 3;
    run_header("odd_size", mk_hdr(17, 8, 17, 641, 3, hv, tq));
    check("odd_size", "mcu_w_const", co_mcu_w, 41);
    check("odd_size", "mcu_h_const", co_mcu_h, 2);
    gap_max = 0;

    hv = '{8'h11, 8'h00, 8'h00, 8'h00};
    tq = '{8'd0, 8'd0, 8'd0, 8'd0};
    run_header("gray", mk_hdr(11, 8, 8, 8, 1, hv, tq));
    check("gray", "mcu_const", {co_mcu_w, co_mcu_h}, {13'd1, 13'd1});
    check("gray", "hfac_const", co_hfac, 12'h001);

    hv = '{8'h22, 8'h11, 8'h11, 8'h11};
    tq = '{8'd0, 8'd1, 8'd1, 8'd0};
    run_header("err_prec", mk_hdr(17, 12, 480, 640, 3, hv, tq));
    check("err_prec", "code_const", co_err_code, 1);
    hv[0] = 8'h31;
    run_header("err_fac", mk_hdr(17, 8, 480, 640, 3, hv, tq));
    check("err_fac", "code_const", co_err_code, 3);
    hv[0] = 8'h22;
    run_header("err_len", mk_hdr(18, 8, 480, 640, 3, hv, tq));
    check("err_len", "code_const", co_err_code, 5);
    hv[0] = 8'h44;
    run_header("err_blk", mk_hdr(17, 8, 480, 640, 3, hv, tq));
    check("err_blk", "code_const", co_err_code, 7);

    // Reset while the second component's HV byte is on the bus
    hv = '{8'h21, 8'h11, 8'h11, 8'h11};
    q = mk_hdr(17, 8, 100, 200, 3, hv, tq);
    sof_start = 1'b1;
    @(posedge clk); #1;
    sof_start = 1'b0;
    for (int i = 0; i < 12; i++) send_byte(q[i]);
    check("rst_mid", "in_ready_hv", in_ready, 1);
    rst = 1'b0; in_valid = 1'b1; in_data = q[12];
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    check_zero("rst_mid");
    run_header("after_rst", q);

    // frm_clr beats sof_start and a valid byte in the same cycle
    frm_clr = 1'b1; sof_start = 1'b1; in_valid = 1'b1; in_data = 8'h00;
    @(posedge clk); #1;
    frm_clr = 1'b0; sof_start = 1'b0; in_valid = 1'b0;
    check_zero("frm_clr");
    @(posedge clk); #1;
    check("frm_clr", "still_idle", in_ready, 0);
    run_header("after_clr", q);

    for (int r = 0; r < 30; r++) begin
      sel = int'($urandom_range(0, 9));
      nf = (sel < 3) ? 1 : (sel < 6) ? 3 : (sel < 9) ? 4 : int'($urandom_range(0, 6));
      p  = ($urandom_range(0, 11) == 0) ? 12 : 8;
      y  = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 4000));
      x  = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 65535));
      lf = 8 + 3 * nf + (($urandom_range(0, 11) == 0) ? 1 : 0);
      for (int c = 0; c < 4; c++) begin
        hv[c] = {rand_fac(), rand_fac()};
        tq[c] = ($urandom_range(0, 15) == 0) ? 8'd5 : 8'($urandom_range(0, 3));
      end
      gap_max = int'($urandom_range(0, 2));
      run_header("rand", mk_hdr(lf, p, y, x, nf, hv, tq));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/jpeg_sof_parser.md
Name: jpeg_sof_parser

Overview:
- Byte-serial SOF0/SOF1 segment parser for the JPEG decoder front end. Sits after the marker detector and feeds frame geometry to the MCU scheduler and the dequantiser.
- Generalises the fixed three-component 4:1:1 / 4:4:4 frame header logic. Handles 1..MAX_COMP components with arbitrary H/V sampling factors (1, 2, 4).
- Derives the MCU grid, checks header consistency and reports a coded error.

Parameters:
MAX_COMP, 4, maximum number of frame components stored (legal values 3..4)
MCU_BITS, 13, width of the MCU column/row count outputs

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
sof_start  in  1  pulse: SOF marker consumed, next accepted byte is Lf[15:8]
frm_clr  in  1  synchronous clear of all outputs and FSM (new image)
in_data  in  8  segment byte
in_valid  in  1  byte valid
in_ready  out  1  parser accepts byte
co_en  out  1  header parsed and valid (level)
co_err  out  1  header rejected (level)
co_err_code  out  3  error reason
co_width  out  16  X
co_height  out  16  Y
co_ncomp  out  3  Nf
co_hfac  out  3*MAX_COMP  per-component H (component i at [3i+2:3i])
co_vfac  out  3*MAX_COMP  per-component V
co_qt  out  2*MAX_COMP  per-component Tq
co_hmax  out  3  max H
co_vmax  out  3  max V
co_blk_per_mcu  out  4  sum of H*V
co_mcu_w  out  MCU_BITS  MCUs per row
co_mcu_h  out  MCU_BITS  MCU rows

Behaviour:
- Reset (rst=0) or frm_clr=1: FSM to IDLE; all outputs 0; in_ready=0. frm_clr has priority over sof_start and bytes in the same cycle.
- A byte is accepted on in_valid & in_ready.
- in_ready=1 only in the byte states LEN_HI..C_TQ. It is 0 in IDLE, CALC, DONE and ERR.
- FSM states and transitions:
  - IDLE -> LEN_HI on sof_start.
  - Then one state per accepted byte: LEN_HI, LEN_LO, PREC, Y_HI, Y_LO, X_HI, X_LO, NF.
  - Then per component: C_ID, C_HV, C_TQ, repeated Nf times. A 3-bit component counter wraps back to C_ID.
  - After the last C_TQ -> CALC (1 cycle) -> DONE or ERR.
- sof_start while not in IDLE restarts at LEN_HI and clears co_en/co_err.
- Field storage:
  - Component ID is consumed, not stored.
  - H = HV[7:4], V = HV[3:0], Tq = byte[1:0].
  - Components with index >= Nf keep factor 0.
  - co_hmax/co_vmax are updated as each C_HV byte is accepted.
  - co_blk_per_mcu accumulates H*V per component (saturating at 15).
- Error detection is immediate: the FSM goes to ERR on the accepting cycle and does not wait for CALC. Codes, first hit wins:
  - 1: PREC != 8
  - 2: Nf is 0, 2, or > MAX_COMP
  - 3: H or V not in {1,2,4}
  - 4: Tq byte > 3
  - 5: Lf != 8+3*Nf (checked at NF)
  - 6: X == 0 or Y == 0 (checked at NF)
  - 7: blk_per_mcu > 10 (checked in CALC)
- CALC computes:
  - co_mcu_w = ceil(X / (8*hmax)), co_mcu_h = ceil(Y / (8*vmax)).
  - Shift by 3+log2(max), then +1 if any discarded bit is nonzero; truncate to MCU_BITS.
- co_en rises the cycle after CALC, i.e. 1 cycle after the last byte is accepted. Outputs are stable while co_en=1.
- co_en and co_err are never both 1.
- ERR and DONE hold until sof_start, frm_clr or reset.
- Stalls (in_valid=0) may occur between any bytes and have no effect on state.

Test Plan:
- 4:2:0 header (Lf=17, P=8, Y=480, X=640, Nf=3; Y HV=0x22, Tq=0; Cb/Cr HV=0x11, Tq=1), bytes back-to-back -> co_en=1 one cycle after the last byte; hmax=vmax=2; co_mcu_w=40, co_mcu_h=30; blk_per_mcu=6; co_qt=0b010100.
- Same header with X=641, Y=17, plus random in_valid gaps -> co_mcu_w=41, co_mcu_h=2; result identical regardless of gaps.
- Grayscale header (Lf=11, Nf=1, HV=0x11, X=8, Y=8) -> co_mcu_w=1, co_mcu_h=1; co_ncomp=1; upper co_hfac fields = 0.
- Error headers:
  - P=12 -> co_err=1, code=1, in_ready=0.
  - HV=0x31 -> code 3.
  - Lf=18 with Nf=3 -> code 5.
  - Y HV=0x44 with chroma 0x11 -> code 7.
- rst=0 mid-component (during C_HV of component 2) -> next cycle all outputs 0 and FSM in IDLE; a fresh sof_start plus a full valid header then parses correctly.
- frm_clr asserted in the same cycle as sof_start and a valid byte -> FSM stays IDLE and the byte is not consumed.
